// File: rtl/alu_writeback_if.sv
// Data-memory port between the writeback stage and the memory system.
// The stage drives the request side; the memory answers with ack/rvalid.
interface alu_writeback_if;
  logic        req;
  logic        we;
  logic        byte_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, byte_en, addr, wdata,
    input  ack, rvalid, rdata
  );

  modport slave (
    input  req, we, byte_en, addr, wdata,
    output ack, rvalid, rdata
  );
endinterface

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: register-file commits, load/store
// transactions on the data port and PC redirects for branches and JALR.
package definitions;
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs;
  } instruction_s;

  localparam logic [15:0] kADDU  = 16'b000000_??????????;
  localparam logic [15:0] kSUBU  = 16'b000001_??????????;
  localparam logic [15:0] kSLLV  = 16'b000010_??????????;
  localparam logic [15:0] kSRAV  = 16'b000011_??????????;
  localparam logic [15:0] kSRLV  = 16'b000100_??????????;
  localparam logic [15:0] kAND   = 16'b000101_??????????;
  localparam logic [15:0] kOR    = 16'b000110_??????????;
  localparam logic [15:0] kNOR   = 16'b000111_??????????;
  localparam logic [15:0] kSLT   = 16'b001000_??????????;
  localparam logic [15:0] kSLTU  = 16'b001001_??????????;
  localparam logic [15:0] kMOV   = 16'b001010_??????????;
  localparam logic [15:0] kROL   = 16'b001011_??????????;
  localparam logic [15:0] kBAR   = 16'b001100_??????????;
  localparam logic [15:0] kNOP   = 16'b001101_??????????;
  localparam logic [15:0] kBEQZ  = 16'b010000_??????????;
  localparam logic [15:0] kBNEQZ = 16'b010001_??????????;
  localparam logic [15:0] kBGTZ  = 16'b010010_??????????;
  localparam logic [15:0] kBLTZ  = 16'b010011_??????????;
  localparam logic [15:0] kJALR  = 16'b010100_??????????;
  localparam logic [15:0] kLW    = 16'b011000_??????????;
  localparam logic [15:0] kLBU   = 16'b011001_??????????;
  localparam logic [15:0] kSW    = 16'b011010_??????????;
  localparam logic [15:0] kSB    = 16'b011011_??????????;
endpackage

module alu_writeback
  import definitions::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  output logic          ready_o,
  input  instruction_s  op_i,
  input  logic [4:0]    wb_addr_i,
  input  logic [31:0]   result_i,
  input  logic          jump_now_i,
  input  logic [31:0]   br_target_i,
  input  logic [31:0]   st_addr_i,
  output logic          rf_we_o,
  output logic [4:0]    rf_waddr_o,
  output logic [31:0]   rf_wdata_o,
  output logic          redirect_o,
  output logic [31:0]   redirect_pc_o,
  alu_writeback_if.master mem
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT_DATA, WB
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE,
    C_BRANCH, C_JALR, C_OTHER
  } cls_e;

  state_e      state, state_d;
  cls_e        cls;
  logic        rf_we_d, redirect_d;
  logic [4:0]  rf_waddr_d, dst_q, dst_d;
  logic [31:0] rf_wdata_d, redirect_pc_d;
  logic        req_q, req_d, we_q, we_d;
  logic        bsel_q, bsel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  lane;

  assign ready_o     = (state == IDLE);
  assign mem.req     = req_q;
  assign mem.we      = we_q;
  assign mem.byte_en = bsel_q;
  assign mem.addr    = addr_q;
  assign mem.wdata   = wdata_q;

  always_comb begin
    cls = C_OTHER;
    unique casez (op_i)
      kADDU, kSUBU, kSLLV, kSRAV,
      kSRLV, kAND, kOR, kNOR,
      kSLT, kSLTU, kROL, kMOV:
        cls = C_ALU;
      kLW, kLBU:       cls = C_LOAD;
      kSW, kSB:        cls = C_STORE;
      kBEQZ, kBNEQZ,
      kBGTZ, kBLTZ:    cls = C_BRANCH;
      kJALR:           cls = C_JALR;
      default:         cls = C_OTHER;
    endcase
  end

  // Byte lane picked by the latched address, lane 0 = bits 7:0
  always_comb begin
    lane = mem.rdata[7:0];
    unique case (addr_q[1:0])
      2'd0: lane = mem.rdata[7:0];
      2'd1: lane = mem.rdata[15:8];
      2'd2: lane = mem.rdata[23:16];
      2'd3: lane = mem.rdata[31:24];
      default: lane = mem.rdata[7:0];
    endcase
  end

  always_comb begin
    state_d       = state;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_o;
    rf_wdata_d    = rf_wdata_o;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_o;
    req_d         = req_q;
    we_d          = we_q;
    bsel_d        = bsel_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    dst_d         = dst_q;
    unique case (state)
      IDLE: begin
        if (valid_i) begin
          unique case (cls)
            C_ALU: begin
              if (|wb_addr_i) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = wb_addr_i;
                rf_wdata_d = result_i;
              end
            end
            C_BRANCH: begin
              if (jump_now_i) begin
                redirect_d    = 1'b1;
                redirect_pc_d = br_target_i;
              end
            end
            C_JALR: begin
              redirect_d    = 1'b1;
              redirect_pc_d = result_i;
            end
            C_LOAD: begin
              req_d   = 1'b1;
              we_d    = 1'b0;
              bsel_d  = (op_i.opcode == kLBU[15:10]);
              addr_d  = result_i;
              dst_d   = wb_addr_i;
              state_d = REQ;
            end
            C_STORE: begin
              req_d   = 1'b1;
              we_d    = 1'b1;
              bsel_d  = (op_i.opcode == kSB[15:10]);
              addr_d  = st_addr_i;
              wdata_d = result_i;
              state_d = REQ;
            end
            default: ;
          endcase
        end
      end
      REQ: begin
        if (mem.ack) begin
          req_d   = 1'b0;
          state_d = we_q ? IDLE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (mem.rvalid) begin
          state_d = WB;
          if (|dst_q) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = dst_q;
            rf_wdata_d = bsel_q ? {24'h0, lane}
                                : mem.rdata;
          end
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rf_we_o       <= 1'b0;
      rf_waddr_o    <= 5'd0;
      rf_wdata_o    <= 32'd0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= 32'd0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      bsel_q        <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      dst_q         <= 5'd0;
    end else begin
      state         <= state_d;
      rf_we_o       <= rf_we_d;
      rf_waddr_o    <= rf_waddr_d;
      rf_wdata_o    <= rf_wdata_d;
      redirect_o    <= redirect_d;
      redirect_pc_o <= redirect_pc_d;
      req_q         <= req_d;
      we_q          <= we_d;
      bsel_q        <= bsel_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      dst_q         <= dst_d;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios, then a random
// instruction stream against a transaction-level reference model.
module tb_alu_writeback;
  import definitions::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_i;
  logic         ready_o;
  instruction_s op_i;
  logic [4:0]   wb_addr_i;
  logic [31:0]  result_i;
  logic         jump_now_i;
  logic [31:0]  br_target_i;
  logic [31:0]  st_addr_i;
  logic         rf_we_o;
  logic [4:0]   rf_waddr_o;
  logic [31:0]  rf_wdata_o;
  logic         redirect_o;
  logic [31:0]  redirect_pc_o;

  alu_writeback_if mif ();

  alu_writeback dut (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .op_i          (op_i),
    .wb_addr_i     (wb_addr_i),
    .result_i      (result_i),
    .jump_now_i    (jump_now_i),
    .br_target_i   (br_target_i),
    .st_addr_i     (st_addr_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .mem           (mif)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] O_ADDU = 6'h00;
  localparam logic [5:0] O_BEQZ = 6'h10;
  localparam logic [5:0] O_JALR = 6'h14;
  localparam logic [5:0] O_LW   = 6'h18;
  localparam logic [5:0] O_LBU  = 6'h19;
  localparam logic [5:0] O_SW   = 6'h1A;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i    = 1'b0;
    mif.ack    = 1'b0;
    mif.rvalid = 1'b0;
  endtask

  task automatic drive(input logic [5:0]  opc,
                       input logic [4:0]  wb,
                       input logic [31:0] res,
                       input logic        jmp,
                       input logic [31:0] brt,
                       input logic [31:0] sta);
    valid_i     = 1'b1;
    op_i        = {opc, 10'($urandom)};
    wb_addr_i   = wb;
    result_i    = res;
    jump_now_i  = jmp;
    br_target_i = brt;
    st_addr_i   = sta;
  endtask

  task automatic check_rst(input string p);
    check({p, "_rf_we"}, 32'(rf_we_o), 0);
    check({p, "_rf_wa"}, 32'(rf_waddr_o), 0);
    check({p, "_rf_wd"}, rf_wdata_o, 0);
    check({p, "_redir"}, 32'(redirect_o), 0);
    check({p, "_rpc"}, redirect_pc_o, 0);
    check({p, "_req"}, 32'(mif.req), 0);
    check({p, "_mwe"}, 32'(mif.we), 0);
    check({p, "_mbyte"}, 32'(mif.byte_en), 0);
    check({p, "_maddr"}, mif.addr, 0);
    check({p, "_mwdata"}, mif.wdata, 0);
    check({p, "_ready"}, 32'(ready_o), 1);
  endtask

  // 0 alu, 1 load, 2 store, 3 branch, 4 jalr, 5 other
  function automatic int cls_of(input logic [5:0] o);
    if (o <= 6'h0B) return 0;
    if (o >= 6'h10 && o <= 6'h13) return 3;
    if (o == 6'h14) return 4;
    if (o == 6'h18 || o == 6'h19) return 1;
    if (o == 6'h1A || o == 6'h1B) return 2;
    return 5;
  endfunction

  logic [5:0] opcs [23] = '{
    6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
    6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
    6'h0C, 6'h0D, 6'h10, 6'h11, 6'h12, 6'h13,
    6'h14, 6'h18, 6'h19, 6'h1A, 6'h1B
  };

  int          mode, dly, beats, ty;
  logic        e_we, e_rd;
  logic [4:0]  e_wa, m_dst, wb;
  logic [31:0] e_wd, e_pc, res, brt, sta, rd;
  logic        m_we, m_byte, jmp;
  logic [31:0] m_addr, m_wdata;
  logic [5:0]  opc;

  initial begin
    reset = 1'b1;
    idle();
    mif.rdata = 32'h0;
    op_i = '0;
    wb_addr_i = '0;
    result_i = '0;
    jump_now_i = 1'b0;
    br_target_i = '0;
    st_addr_i = '0;
    step();
    step();
    reset = 1'b0;
    check_rst("rst");
    step();
    check_rst("rst1");

    // ALU writeback, then a write to r0
    drive(O_ADDU, 5'd5, 32'h7, 1'b0, 32'h0, 32'h0);
    step();
    check("alu_we", 32'(rf_we_o), 1);
    check("alu_wa", 32'(rf_waddr_o), 5);
    check("alu_wd", rf_wdata_o, 32'h7);
    drive(O_ADDU, 5'd0, 32'h1234, 1'b0, 32'h0, 32'h0);
    step();
    check("alu_r0_we", 32'(rf_we_o), 0);

    // Branch taken, branch not taken, JALR
    drive(O_BEQZ, 5'd1, 32'h0, 1'b1, 32'h40, 32'h0);
    step();
    check("br_redir", 32'(redirect_o), 1);
    check("br_pc", redirect_pc_o, 32'h40);
    drive(O_BEQZ, 5'd1, 32'h0, 1'b0, 32'h99, 32'h0);
    step();
    check("br_nt_redir", 32'(redirect_o), 0);
    check("br_nt_we", 32'(rf_we_o), 0);
    drive(O_JALR, 5'd1, 32'h100, 1'b0, 32'h0, 32'h0);
    step();
    check("jalr_redir", 32'(redirect_o), 1);
    check("jalr_pc", redirect_pc_o, 32'h100);
    idle();
    step();
    check("jalr_pulse", 32'(redirect_o), 0);

    // LBU with a delayed ack and delayed data
    drive(O_LBU, 5'd9, 32'h13, 1'b0, 32'h0, 32'h0);
    step();
    idle();
    check("lbu_req1", 32'(mif.req), 1);
    check("lbu_byte", 32'(mif.byte_en), 1);
    check("lbu_we", 32'(mif.we), 0);
    check("lbu_addr", mif.addr, 32'h13);
    check("lbu_rdy1", 32'(ready_o), 0);
    step();
    check("lbu_req2", 32'(mif.req), 1);
    check("lbu_rdy2", 32'(ready_o), 0);
    step();
    check("lbu_req3", 32'(mif.req), 1);
    check("lbu_rdy3", 32'(ready_o), 0);
    mif.ack = 1'b1;
    step();
    mif.ack = 1'b0;
    check("lbu_req4", 32'(mif.req), 0);
    check("lbu_rdy4", 32'(ready_o), 0);
    step();
    check("lbu_rdy5", 32'(ready_o), 0);
    check("lbu_we5", 32'(rf_we_o), 0);
    step();
    check("lbu_rdy6", 32'(ready_o), 0);
    mif.rvalid = 1'b1;
    mif.rdata = 32'hAABBCCDD;
    step();
    mif.rvalid = 1'b0;
    check("lbu_rf_we", 32'(rf_we_o), 1);
    check("lbu_rf_wa", 32'(rf_waddr_o), 9);
    check("lbu_rf_wd", rf_wdata_o, 32'hAA);
    check("lbu_rdy7", 32'(ready_o), 0);
    step();
    check("lbu_rf_pulse", 32'(rf_we_o), 0);
    check("lbu_rdy8", 32'(ready_o), 1);

    // Store acked in its first request cycle
    drive(O_SW, 5'd4, 32'hDEADBEEF, 1'b0, 32'h0, 32'h80);
    step();
    idle();
    check("sw_req", 32'(mif.req), 1);
    check("sw_we", 32'(mif.we), 1);
    check("sw_byte", 32'(mif.byte_en), 0);
    check("sw_addr", mif.addr, 32'h80);
    check("sw_wdata", mif.wdata, 32'hDEADBEEF);
    check("sw_rdy1", 32'(ready_o), 0);
    mif.ack = 1'b1;
    step();
    mif.ack = 1'b0;
    check("sw_rdy2", 32'(ready_o), 1);
    check("sw_req_off", 32'(mif.req), 0);
    check("sw_rf_we", 32'(rf_we_o), 0);

    // Reset while waiting for load data
    drive(O_LW, 5'd7, 32'h200, 1'b0, 32'h0, 32'h0);
    step();
    idle();
    mif.ack = 1'b1;
    step();
    mif.ack = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_rst("mrst");
    mif.rvalid = 1'b1;
    mif.rdata = 32'h11223344;
    step();
    mif.rvalid = 1'b0;
    check("mrst_we1", 32'(rf_we_o), 0);
    check("mrst_rdy", 32'(ready_o), 1);
    step();
    check("mrst_we2", 32'(rf_we_o), 0);
    drive(O_ADDU, 5'd3, 32'h55, 1'b0, 32'h0, 32'h0);
    step();
    idle();
    check("mrst_alu_we", 32'(rf_we_o), 1);
    check("mrst_alu_wa", 32'(rf_waddr_o), 3);
    check("mrst_alu_wd", rf_wdata_o, 32'h55);

    // Stray handshakes in IDLE
    mif.ack = 1'b1;
    step();
    mif.ack = 1'b0;
    mif.rvalid = 1'b1;
    step();
    mif.rvalid = 1'b0;
    check("stray_req", 32'(mif.req), 0);
    check("stray_we", 32'(rf_we_o), 0);
    check("stray_redir", 32'(redirect_o), 0);
    check("stray_rdy", 32'(ready_o), 1);
    step();
    check("stray_we2", 32'(rf_we_o), 0);
    check("stray_rdy2", 32'(ready_o), 1);

    // Random stream against a transaction-level model
    mode = 0;
    dly = 0;
    beats = 0;
    e_we = 1'b0;
    e_rd = 1'b0;
    e_wa = '0;
    e_wd = '0;
    e_pc = '0;
    m_we = 1'b0;
    m_byte = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    m_dst = '0;
    for (int cyc = 0; cyc < 5000 && beats < 400; cyc++) begin
      check("r_ready", 32'(ready_o), 32'(mode == 0));
      check("r_rf_we", 32'(rf_we_o), 32'(e_we));
      if (e_we) begin
        check("r_rf_wa", 32'(rf_waddr_o), 32'(e_wa));
        check("r_rf_wd", rf_wdata_o, e_wd);
      end
      check("r_redir", 32'(redirect_o), 32'(e_rd));
      if (e_rd) check("r_rpc", redirect_pc_o, e_pc);
      check("r_req", 32'(mif.req), 32'(mode == 1));
      if (mode == 1) begin
        check("r_mwe", 32'(mif.we), 32'(m_we));
        check("r_mbyte", 32'(mif.byte_en), 32'(m_byte));
        check("r_maddr", mif.addr, m_addr);
        if (m_we) check("r_mwdata", mif.wdata, m_wdata);
      end
      e_we = 1'b0;
      e_rd = 1'b0;
      idle();
      case (mode)
        0: begin
          if ($urandom_range(0, 7) == 0) mif.ack = 1'b1;
          if ($urandom_range(0, 7) == 0) begin
            mif.rvalid = 1'b1;
            mif.rdata = $urandom;
          end
          if ($urandom_range(0, 4) != 0) begin
            opc = opcs[$urandom_range(0, 22)];
            wb  = ($urandom_range(0, 5) == 0) ? 5'd0
                                               : 5'($urandom);
            res = $urandom;
            jmp = 1'($urandom);
            brt = $urandom;
            sta = $urandom;
            drive(opc, wb, res, jmp, brt, sta);
            beats++;
            ty = cls_of(opc);
            if (ty == 0) begin
              e_we = (wb != 0);
              e_wa = wb;
              e_wd = res;
            end else if (ty == 3) begin
              e_rd = jmp;
              e_pc = brt;
            end else if (ty == 4) begin
              e_rd = 1'b1;
              e_pc = res;
            end else if (ty == 1) begin
              m_we = 1'b0;
              m_byte = (opc == O_LBU);
              m_addr = res;
              m_dst = wb;
              mode = 1;
            end else if (ty == 2) begin
              m_we = 1'b1;
              m_byte = (opc != O_SW);
              m_addr = sta;
              m_wdata = res;
              mode = 1;
            end
          end
        end
        1: begin
          if ($urandom_range(0, 5) == 0) begin
            mif.rvalid = 1'b1;
            mif.rdata = $urandom;
          end
          if ($urandom_range(0, 2) == 0) begin
            mif.ack = 1'b1;
            if (m_we) mode = 0;
            else begin
              mode = 2;
              dly = $urandom_range(1, 3);
            end
          end
        end
        2: begin
          dly--;
          if (dly == 0) begin
            rd = $urandom;
            mif.rvalid = 1'b1;
            mif.rdata = rd;
            e_we = (m_dst != 0);
            e_wa = m_dst;
            e_wd = m_byte ? ((rd >> (8 * m_addr[1:0])) & 32'hFF)
                          : rd;
            mode = 4;
          end else if ($urandom_range(0, 3) == 0) begin
            mif.ack = 1'b1;
          end
        end
        default: mode = 0;
      endcase
      step();
    end
    check("r_beats", 32'(beats), 400);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
